// File: rtl/tape_pkg.sv
// Shared definitions for the cassette-image SDRAM arbiter: address width,
// FSM encoding and default command timing.
package tape_pkg;
    localparam int unsigned ADDR_W      = 25;
    localparam int unsigned CMD_GAP_DEF = 8;
    localparam int unsigned RD_LAT_DEF  = 6;

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, GAP} state_t;

    // One past the given address, pinned at the top of the address space.
    function automatic logic [ADDR_W-1:0] addr_end(input logic [ADDR_W-1:0] a);
        return (a == '1) ? a : a + ADDR_W'(1);
    endfunction
endpackage

// File: rtl/tape_wr_fifo.sv
// Loader write buffer: synchronous FIFO with registered empty/full flags;
// a push into a full FIFO without a simultaneous pop is dropped and reported.
module tape_wr_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             drop
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nx;
    logic             full, push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        drop     = push && !push_ok;
        count_nx = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
            empty <= (count_nx == '0);
            full  <= (count_nx == (AW+1)'(DEPTH));
        end
    end
endmodule

// File: rtl/tape_mem_arbiter.sv
// Sequences loader writes and cassette reads onto the byte-wide SDRAM,
// enforcing command spacing and read latency, and tracks loaded tape length.
module tape_mem_arbiter
    import tape_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CMD_GAP    = CMD_GAP_DEF,
    parameter int unsigned RD_LAT     = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_active,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_overflow,
    input  logic              cas_req,
    input  logic [ADDR_W-1:0] cas_addr,
    output logic              cas_ack,
    output logic [7:0]        cas_data,
    output logic [ADDR_W-1:0] tape_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout
);
    localparam int unsigned FW    = ADDR_W + 8;
    localparam int unsigned GAP_W = $clog2(CMD_GAP + 1);
    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

    state_t            state, state_nx;
    logic [FW-1:0]     fifo_head;
    logic              fifo_empty, fifo_drop;
    logic [GAP_W-1:0]  gap_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              issue_wr, issue_rd, capture;
    logic              ld_active_q, ld_rise;
    logic [ADDR_W-1:0] len_base, len_cand, len_nx;

    tape_wr_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (ld_wr),
        .wdata  ({ld_addr, ld_data}),
        .pop    (issue_wr),
        .rdata  (fifo_head),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

    assign ld_rise = ld_active && !ld_active_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                // A strobe arriving this cycle is not yet visible in the FIFO
                // flags, so it also holds off a read to keep writes first.
                if (!fifo_empty) begin
                    issue_wr = 1'b1;
                    state_nx = WRITE;
                end else if (cas_req && !ld_active && !ld_wr) begin
                    issue_rd = 1'b1;
                    state_nx = READ;
                end
            end
            WRITE:   state_nx = GAP;
            READ:    state_nx = WAIT_RD;
            WAIT_RD: begin
                if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                    capture  = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP:     if (gap_cnt >= GAP_W'(CMD_GAP - 2)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        len_base = ld_rise ? '0 : tape_len;
        len_cand = addr_end(fifo_head[FW-1:8]);
        len_nx   = (issue_wr && len_cand > len_base) ? len_cand : len_base;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_we      <= 1'b0;
            mem_rd      <= 1'b0;
            cas_ack     <= 1'b0;
            cas_data    <= '0;
            gap_cnt     <= '0;
            lat_cnt     <= '0;
            ld_active_q <= 1'b0;
            ld_overflow <= 1'b0;
            tape_len    <= '0;
        end else begin
            mem_we      <= issue_wr;
            mem_rd      <= issue_rd;
            cas_ack     <= capture;
            ld_active_q <= ld_active;
            tape_len    <= len_nx;
            if (issue_wr) begin
                mem_addr <= fifo_head[FW-1:8];
                mem_din  <= fifo_head[7:0];
            end else if (issue_rd) begin
                mem_addr <= cas_addr;
            end
            if (capture) cas_data <= mem_dout;
            if (issue_wr || issue_rd)              gap_cnt <= '0;
            else if (gap_cnt != GAP_W'(CMD_GAP))   gap_cnt <= gap_cnt + GAP_W'(1);
            if (issue_rd)                          lat_cnt <= '0;
            else if (state == WAIT_RD)             lat_cnt <= lat_cnt + LAT_W'(1);
            if (fifo_drop)    ld_overflow <= 1'b1;
            else if (ld_rise) ld_overflow <= 1'b0;
        end
    end
endmodule
